dds_key_ctrl: RTL

Key-driven configuration controller for the DDS waveform datapath. It debounces the eight front-panel keys and edits a shadow set of DDS parameters: frequency word, amplitude scale and waveform select. On the commit key it transfers the shadow set to the active outputs with a valid/ready handshake. It sits between `key_in` and the DDS phase accumulator / waveform ROM / DA output stage inside `top`.

---
 rtl/dds_key_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dds_key_ctrl.sv
// Key-driven DDS configuration controller: debounces eight active-low keys,
// edits a shadow parameter set and commits it to the active outputs via valid/ready.
module dds_key_ctrl #(
  parameter int unsigned      FW_W            = 32,
  parameter logic [FW_W-1:0]  FW_DEFAULT      = FW_W'(85899),
  parameter logic [FW_W-1:0]  FW_STEP         = FW_W'(85899),
  parameter logic [FW_W-1:0]  FW_MIN          = FW_W'(85899),
  parameter logic [FW_W-1:0]  FW_MAX          = FW_W'(8589935),
  parameter int unsigned      DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk_50M,
  input  logic            rst,
  input  logic [7:0]      key_in,
  input  logic            cfg_ready,
  output logic [FW_W-1:0] freq_word,
  output logic [7:0]      amp_scale,
  output logic [1:0]      wave_sel,
  output logic            cfg_valid,
  output logic            dirty
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [7:0]       AMP_DEFAULT = 8'd255;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        sync1_q, key_sync_q, key_prev_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        key_stable_q, key_stable_dly_q;
  logic [FW_W-1:0]   sh_fw_q, sh_fw_d;
  logic [7:0]        sh_amp_q, sh_amp_d;
  logic [1:0]        sh_wave_q, sh_wave_d;
  logic [FW_W-1:0]   fw_q, fw_d;
  logic [7:0]        amp_q, amp_d;
  logic [1:0]        wave_q, wave_d;
  logic              valid_q, valid_d;
  logic              dirty_q, dirty_d;

  logic [7:0]        press;
  logic              press_any;
  logic [2:0]        press_idx;
  logic [FW_W:0]     fw_sum;
  logic signed [FW_W:0] fw_diff;
  logic [FW_W-1:0]   fw_inc, fw_dec;
  logic [7:0]        amp_next;

  // Input conditioning: one shared counter for all keys; a new level is only
  // accepted once it has been steady for the full count.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sync1_q          <= '1;
      key_sync_q       <= '1;
      key_prev_q       <= '1;
      cnt_q            <= '0;
      key_stable_q     <= '1;
      key_stable_dly_q <= '1;
    end else begin
      sync1_q          <= key_in;
      key_sync_q       <= sync1_q;
      key_prev_q       <= key_sync_q;
      key_stable_dly_q <= key_stable_q;
      if (key_sync_q != key_prev_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((key_sync_q == key_prev_q) && (cnt_q == CNT_MAX)) begin
        key_stable_q <= key_sync_q;
      end
    end
  end

  assign press = key_stable_dly_q & ~key_stable_q;

  always_comb begin
    press_any = 1'b0;
    press_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (press[i] && !press_any) begin
        press_any = 1'b1;
        press_idx = 3'(i);
      end
    end
  end

  // Saturating arithmetic in one extra bit so neither direction can wrap.
  always_comb begin
    fw_sum  = {1'b0, sh_fw_q} + {1'b0, FW_STEP};
    fw_diff = $signed({1'b0, sh_fw_q}) - $signed({1'b0, FW_STEP});
    fw_inc  = (fw_sum > {1'b0, FW_MAX}) ? FW_MAX : fw_sum[FW_W-1:0];
    fw_dec  = (fw_diff < $signed({1'b0, FW_MIN})) ? FW_MIN : fw_diff[FW_W-1:0];
    case (sh_amp_q)
      8'd255:  amp_next = 8'd191;
      8'd191:  amp_next = 8'd127;
      8'd127:  amp_next = 8'd63;
      default: amp_next = 8'd255;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_fw_q   <= FW_DEFAULT;
      sh_amp_q  <= AMP_DEFAULT;
      sh_wave_q <= '0;
      fw_q      <= FW_DEFAULT;
      amp_q     <= AMP_DEFAULT;
      wave_q    <= '0;
      valid_q   <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_fw_q   <= sh_fw_d;
      sh_amp_q  <= sh_amp_d;
      sh_wave_q <= sh_wave_d;
      fw_q      <= fw_d;
      amp_q     <= amp_d;
      wave_q    <= wave_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_fw_d   = sh_fw_q;
    sh_amp_d  = sh_amp_q;
    sh_wave_d = sh_wave_q;
    fw_d      = fw_q;
    amp_d     = amp_q;
    wave_d    = wave_q;
    valid_d   = valid_q;
    dirty_d   = {sh_fw_q, sh_amp_q, sh_wave_q} != {fw_q, amp_q, wave_q};
    case (state_q)
      IDLE: begin
        if (press_any) begin
          case (press_idx)
            3'd0: sh_fw_d   = fw_inc;
            3'd1: sh_fw_d   = fw_dec;
            3'd2: sh_amp_d  = amp_next;
            3'd3: sh_wave_d = sh_wave_q + 2'd1;
            3'd4: begin
              fw_d    = sh_fw_q;
              amp_d   = sh_amp_q;
              wave_d  = sh_wave_q;
              valid_d = 1'b1;
              state_d = COMMIT;
            end
            3'd5: begin
              sh_fw_d   = FW_DEFAULT;
              sh_amp_d  = AMP_DEFAULT;
              sh_wave_d = '0;
            end
            default: ;
          endcase
        end
      end
      COMMIT: begin
        if (cfg_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign freq_word = fw_q;
  assign amp_scale = amp_q;
  assign wave_sel  = wave_q;
  assign cfg_valid = valid_q;
  assign dirty     = dirty_q;

endmodule
